mp_reg_file: RTL and testbench
==============================

// Module: mp_reg_file
// PURPOSE
//  Parametrised multi-port register file: N_RD read ports, N_WR write ports, DEPTH x DATA_WIDTH.
//  Successor to the fixed 2-read/1-write file, adding:
//   - multiple writers;
//   - write-priority resolution;
//   - optional read-after-write bypass;
//   - per-port read-valid;
//   - a sequenced clear engine.
//  Sits in the datapath as shared operand storage between issue and execute stages.
// PARAMETERS
//  DATA_WIDTH  16  bits per entry
//  ADDR_WIDTH  5   address bits; DEPTH = 2**ADDR_WIDTH (32 entries)
//  N_RD        2   read ports (>=1)
//  N_WR        2   write ports (>=1)
//  BYPASS      1   1: same-cycle write data forwarded to reads; 0: reads return pre-write data
// PORTS
//  clk           in   1                  rising-edge clock
//  resetn        in   1                  reset, asynchronous, active-low
//  din           in   N_WR*DATA_WIDTH    write data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  wad           in   N_WR*ADDR_WIDTH    write address per port, same packing
//  wen           in   N_WR               write enable per port
//  rad           in   N_RD*ADDR_WIDTH    read address per port
//  ren           in   N_RD               read enable per port
//  clr           in   1                  start clear sweep (single-cycle pulse)
//  dout          out  N_RD*DATA_WIDTH    registered read data per port
//  rvalid        out  N_RD               dout[j] updated this cycle
//  collision     out  1                  registered: any read/write or write/write address clash
//  wr_collision  out  1                  registered: two enabled writers hit the same address
//  busy          out  1                  clear sweep in progress
// BEHAVIOUR
//  Reset (resetn=0, async):
//   - all entries = 0; dout = 0; rvalid = 0; collision = 0; wr_collision = 0; busy = 0;
//   - FSM = IDLE; clear counter = 0.
//  Write: at posedge, every enabled port writes din[i] to wad[i].
//   - Same address on several enabled ports: highest port index wins, others dropped.
//  Read: latency 1.
//   - ren[j]=1 at edge N -> dout[j] = entry[rad[j]] and rvalid[j]=1 after edge N.
//   - ren[j]=0 -> dout[j] holds last value; rvalid[j]=0.
//  Read/write same address, same cycle:
//   - BYPASS=1 -> dout gets the winning writer's din.
//   - BYPASS=0 -> dout gets the old contents.
//  collision (1 cycle after cause; combines across ports, OR):
//   - some ren[j] & wen[i] with rad[j]==wad[i];
//   - or two wen with equal wad.
//   - wr_collision covers only the write/write case.
//   - Both are held 0 when no qualifying enables are present.
//  Clear FSM: IDLE -> CLEAR on clr=1.
//   - CLEAR writes 0 to entry cnt, cnt++ each cycle.
//   - At cnt==DEPTH-1: write 0, cnt wraps to 0, return to IDLE.
//   - busy=1 for exactly DEPTH cycles, starting the cycle after the clr edge.
//  During CLEAR:
//   - user writes are ignored (no store, no collision);
//   - clr is ignored;
//   - reads proceed normally, returning current contents;
//   - read of entry cnt in the same cycle returns 0 if BYPASS=1, old data if BYPASS=0.
//  Reset mid-sweep: abort to IDLE, busy=0, all entries 0.
//  Address width exactly covers DEPTH; no out-of-range case exists.
// TESTING
//  1. Reset then read all 32 entries -> every dout=0, rvalid=1 one cycle after each ren,
//     collision=0.
//  2. wen[0] wad=3 din=30; next cycle ren[0] rad=3 -> dout[0]=30 one cycle later;
//     ren=0 -> dout holds 30, rvalid=0.
//  3. wen[0] wad=5 din=40 and wen[1] wad=5 din=29, same cycle
//     -> entry5=29, wr_collision=1 and collision=1 next cycle.
//  4. entry1=20; write wad=1 din=100 with ren[0],ren[1] rad=1, same cycle
//     -> BYPASS=1: dout=100,100; BYPASS=0: dout=20,20; collision=1 in both.
//  5. Fill entries 16,17 with 40,29; pulse clr -> busy=1 for 32 cycles;
//     write wad=0 din=7 during sweep dropped; afterwards reads of 0,16,17 return 0.
//  6. Assert resetn=0 at sweep cycle 10 -> busy=0 immediately; entries 0;
//     new clr after release restarts at cnt=0.

Source files
------------

// File: rtl/mp_reg_file.sv
// Multi-port register file (N_RD readers, N_WR writers), with a sequenced clear engine.
// Latency: reads are registered, so data appears 1 cycle after ren; writes commit at the edge.
// Backpressure: none. During a clear sweep busy=1, and user writes are dropped.
module mp_reg_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 5,
  parameter int N_RD       = 2,
  parameter int N_WR       = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [N_WR*DATA_WIDTH-1:0] din,
  input  logic [N_WR*ADDR_WIDTH-1:0] wad,
  input  logic [N_WR-1:0]            wen,
  input  logic [N_RD*ADDR_WIDTH-1:0] rad,
  input  logic [N_RD-1:0]            ren,
  input  logic                       clr,
  output logic [N_RD*DATA_WIDTH-1:0] dout,
  output logic [N_RD-1:0]            rvalid,
  output logic                       collision,
  output logic                       wr_collision,
  output logic                       busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic [DATA_WIDTH-1:0]   mem     [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_data [N_RD];
  logic                    clearing;
  logic [N_WR-1:0]         user_wen;
  logic                    rw_hit;
  logic                    ww_hit;

  // The sweep owns the array, so user writes are masked out while it runs.
  assign clearing = (state == ST_CLEAR);
  assign user_wen = clearing ? '0 : wen;

  // Clear sequencer: walks cnt across every entry once, and busy mirrors the CLEAR state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Storage update: the sweep zeroes one entry per cycle; otherwise the last enabled port wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (clearing) begin
      mem[cnt] <= '0;
    end else begin
      for (int i = 0; i < N_WR; i++) begin
        if (wen[i]) begin
          mem[wad[i*ADDR_WIDTH +: ADDR_WIDTH]] <= din[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Read mux with optional forwarding of this cycle's winning write (or sweep zero).
  always_comb begin
    for (int j = 0; j < N_RD; j++) begin
      rd_data[j] = mem[rad[j*ADDR_WIDTH +: ADDR_WIDTH]];
      if (BYPASS) begin
        if (clearing) begin
          if (rad[j*ADDR_WIDTH +: ADDR_WIDTH] == cnt) begin
            rd_data[j] = '0;
          end
        end else begin
          for (int i = 0; i < N_WR; i++) begin
            if (wen[i] && (wad[i*ADDR_WIDTH +: ADDR_WIDTH] == rad[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
              rd_data[j] = din[i*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
      end
    end
  end

  // Address clash detection over the writes that will actually be committed.
  always_comb begin
    rw_hit = 1'b0;
    ww_hit = 1'b0;
    for (int i = 0; i < N_WR; i++) begin
      for (int j = 0; j < N_RD; j++) begin
        if (user_wen[i] && ren[j] &&
            (wad[i*ADDR_WIDTH +: ADDR_WIDTH] == rad[j*ADDR_WIDTH +: ADDR_WIDTH])) begin
          rw_hit = 1'b1;
        end
      end
      for (int k = i + 1; k < N_WR; k++) begin
        if (user_wen[i] && user_wen[k] &&
            (wad[i*ADDR_WIDTH +: ADDR_WIDTH] == wad[k*ADDR_WIDTH +: ADDR_WIDTH])) begin
          ww_hit = 1'b1;
        end
      end
    end
  end

  // Output registers: dout only updates on enabled ports, so idle ports hold their last value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout         <= '0;
      rvalid       <= '0;
      collision    <= 1'b0;
      wr_collision <= 1'b0;
    end else begin
      rvalid       <= ren;
      collision    <= rw_hit | ww_hit;
      wr_collision <= ww_hit;
      for (int j = 0; j < N_RD; j++) begin
        if (ren[j]) begin
          dout[j*DATA_WIDTH +: DATA_WIDTH] <= rd_data[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_mp_reg_file.sv
// Self-checking bench for mp_reg_file: directed scenarios, then random traffic against a reference model.
// Latency: every expectation is compared 1ns after the edge that produces it.
// Backpressure: none; the sweep length is measured with bounded loops.
module tb_mp_reg_file;

  localparam int  DW     = 16;
  localparam int  AW     = 5;
  localparam int  NE     = 32;
  localparam bit  BYPASS = 1'b1;

  logic          clk = 1'b0;
  logic          resetn;
  logic [2*DW-1:0] din;
  logic [2*AW-1:0] wad;
  logic [1:0]    wen;
  logic [2*AW-1:0] rad;
  logic [1:0]    ren;
  logic          clr;
  logic [2*DW-1:0] dout;
  logic [1:0]    rvalid;
  logic          collision;
  logic          wr_collision;
  logic          busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model state: array contents, sweep progress, expected registered outputs
  logic [DW-1:0] m_mem [NE];
  bit            m_busy;
  int            m_pos;
  logic [DW-1:0] e_dout [2];
  logic [1:0]    e_rvalid;
  logic          e_col;
  logic          e_wcol;

  mp_reg_file #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .N_RD(2), .N_WR(2), .BYPASS(BYPASS)
  ) dut (
    .clk(clk), .resetn(resetn), .din(din), .wad(wad), .wen(wen),
    .rad(rad), .ren(ren), .clr(clr), .dout(dout), .rvalid(rvalid),
    .collision(collision), .wr_collision(wr_collision), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    din = '0; wad = '0; wen = '0; rad = '0; ren = '0; clr = 1'b0;
  endtask

  task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[i] = 1'b1;
    wad[i*AW +: AW] = a;
    din[i*DW +: DW] = d;
  endtask

  task automatic set_rd(input int j, input logic [AW-1:0] a);
    ren[j] = 1'b1;
    rad[j*AW +: AW] = a;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NE; k++) m_mem[k] = '0;
    m_busy = 1'b0;
    m_pos = 0;
    e_dout[0] = '0;
    e_dout[1] = '0;
    e_rvalid = '0;
    e_col = 1'b0;
    e_wcol = 1'b0;
  endtask

  // Applies one clock of the rules: reads see the pre-edge array (plus forwarding),
  // then writes or the sweep modify it.
  task automatic model_step();
    bit            sweeping;
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    sweeping = m_busy;
    e_col = 1'b0;
    e_wcol = 1'b0;
    e_rvalid = ren;
    for (int j = 0; j < 2; j++) begin
      a = rad[j*AW +: AW];
      for (int i = 0; i < 2; i++)
        if (!sweeping && ren[j] && wen[i] && wad[i*AW +: AW] == a) e_col = 1'b1;
      if (ren[j]) begin
        v = m_mem[a];
        if (BYPASS && sweeping && int'(a) == m_pos) v = '0;
        if (BYPASS && !sweeping) begin
          if (wen[1] && wad[AW +: AW] == a)        v = din[DW +: DW];
          else if (wen[0] && wad[0 +: AW] == a)    v = din[0 +: DW];
        end
        e_dout[j] = v;
      end
    end
    if (!sweeping && wen == 2'b11 && wad[0 +: AW] == wad[AW +: AW]) begin
      e_col = 1'b1;
      e_wcol = 1'b1;
    end
    if (sweeping) begin
      m_mem[m_pos] = '0;
      m_pos++;
      if (m_pos == NE) begin
        m_pos = 0;
        m_busy = 1'b0;
      end
    end else begin
      if (wen[0]) m_mem[wad[0 +: AW]] = din[0 +: DW];
      if (wen[1]) m_mem[wad[AW +: AW]] = din[DW +: DW];
      if (clr) begin
        m_busy = 1'b1;
        m_pos = 0;
      end
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".dout0"}, dout[0 +: DW], e_dout[0]);
    chk({tag, ".dout1"}, dout[DW +: DW], e_dout[1]);
    chk({tag, ".rvalid"}, 16'(rvalid), 16'(e_rvalid));
    chk({tag, ".collision"}, 16'(collision), 16'(e_col));
    chk({tag, ".wr_collision"}, 16'(wr_collision), 16'(e_wcol));
    chk({tag, ".busy"}, 16'(busy), 16'(m_busy));
    @(negedge clk);
  endtask

  initial begin
    int busy_cycles;
    int guard;

    idle_inputs();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.dout", dout[15:0] | dout[31:16], 16'd0);
    chk("reset.rvalid", 16'(rvalid), 16'd0);
    chk("reset.collision", 16'(collision), 16'd0);
    chk("reset.wr_collision", 16'(wr_collision), 16'd0);
    chk("reset.busy", 16'(busy), 16'd0);
    resetn = 1'b1;
    @(negedge clk);

    // 1: every entry reads back zero after reset
    for (int a = 0; a < NE; a++) begin
      idle_inputs();
      set_rd(0, AW'(a));
      set_rd(1, AW'(NE - 1 - a));
      cycle("t1");
    end
    chk("t1.rvalid_const", 16'(rvalid), 16'd3);

    // 2: write then read, then hold
    idle_inputs(); set_wr(0, 5'd3, 16'd30); cycle("t2w");
    idle_inputs(); set_rd(0, 5'd3);          cycle("t2r");
    chk("t2.dout_const", dout[15:0], 16'd30);
    idle_inputs();                           cycle("t2h");
    chk("t2.hold_const", dout[15:0], 16'd30);
    chk("t2.rvalid_low", 16'(rvalid), 16'd0);

    // 3: write/write clash, higher port wins
    idle_inputs(); set_wr(0, 5'd5, 16'd40); set_wr(1, 5'd5, 16'd29); cycle("t3w");
    chk("t3.wr_collision_const", 16'(wr_collision), 16'd1);
    chk("t3.collision_const", 16'(collision), 16'd1);
    idle_inputs(); set_rd(0, 5'd5); cycle("t3r");
    chk("t3.winner_const", dout[15:0], 16'd29);

    // 4: read/write same address, same cycle
    idle_inputs(); set_wr(0, 5'd1, 16'd20); cycle("t4a");
    idle_inputs(); set_wr(0, 5'd1, 16'd100); set_rd(0, 5'd1); set_rd(1, 5'd1); cycle("t4b");
    chk("t4.dout0_const", dout[15:0], BYPASS ? 16'd100 : 16'd20);
    chk("t4.dout1_const", dout[31:16], BYPASS ? 16'd100 : 16'd20);
    chk("t4.collision_const", 16'(collision), 16'd1);
    chk("t4.wr_collision_const", 16'(wr_collision), 16'd0);

    // 5: clear sweep, with a dropped write and an ignored clr inside it
    idle_inputs(); set_wr(0, 5'd16, 16'd40); set_wr(1, 5'd17, 16'd29); cycle("t5f");
    idle_inputs(); clr = 1'b1; cycle("t5c");
    busy_cycles = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 40) begin
      idle_inputs();
      if (guard == 4) set_wr(0, 5'd0, 16'd7);
      if (guard == 6) clr = 1'b1;
      cycle("t5s");
      if (busy) busy_cycles++;
      guard++;
    end
    chk("t5.busy_cycles", 16'(busy_cycles), 16'd32);
    idle_inputs(); set_rd(0, 5'd0); set_rd(1, 5'd16); cycle("t5r1");
    chk("t5.entry0_const", dout[15:0], 16'd0);
    chk("t5.entry16_const", dout[31:16], 16'd0);
    idle_inputs(); set_rd(0, 5'd17); cycle("t5r2");
    chk("t5.entry17_const", dout[15:0], 16'd0);

    // 6: reset in the middle of a sweep, then restart from entry 0
    idle_inputs(); set_wr(0, 5'd30, 16'd123); set_wr(1, 5'd31, 16'd77); cycle("t6f");
    idle_inputs(); clr = 1'b1; cycle("t6c");
    idle_inputs();
    repeat (9) cycle("t6s");
    #2 resetn = 1'b0;
    #1;
    chk("t6.busy_async", 16'(busy), 16'd0);
    chk("t6.dout_async", dout[15:0] | dout[31:16], 16'd0);
    chk("t6.rvalid_async", 16'(rvalid), 16'd0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    idle_inputs(); set_rd(0, 5'd30); set_rd(1, 5'd31); cycle("t6r");
    chk("t6.entry30_const", dout[15:0], 16'd0);
    idle_inputs(); set_wr(0, 5'd0, 16'd55); set_wr(1, 5'd5, 16'd66); cycle("t6w");
    idle_inputs(); clr = 1'b1; cycle("t6c2");
    idle_inputs(); set_rd(0, 5'd0); set_rd(1, 5'd5); cycle("t6first");
    chk("t6.cnt0_const", dout[15:0], BYPASS ? 16'd0 : 16'd55);
    chk("t6.entry5_const", dout[31:16], 16'd66);
    guard = 0;
    while (busy && guard < 40) begin
      idle_inputs();
      cycle("t6d");
      guard++;
    end
    chk("t6.sweep_done", 16'(busy), 16'd0);

    // Random traffic against the model, concentrated on a few addresses to provoke clashes
    for (int n = 0; n < 400; n++) begin
      idle_inputs();
      wen = 2'($urandom_range(0, 3));
      ren = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        wad[p*AW +: AW] = AW'($urandom_range(0, 7));
        rad[p*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(0, NE - 1) : $urandom_range(0, 7));
        din[p*DW +: DW] = DW'($urandom);
      end
      clr = ($urandom_range(0, 59) == 0);
      cycle("rnd");
    end
    guard = 0;
    while (busy && guard < 40) begin
      idle_inputs();
      cycle("rnd_drain");
      guard++;
    end
    for (int a = 0; a < NE; a += 2) begin
      idle_inputs();
      set_rd(0, AW'(a));
      set_rd(1, AW'(a + 1));
      cycle("final");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
